// File: rtl/ahb_code_pkg.sv
// Shared types for the code-bus SRAM responder.
// Bus encodings, FSM states and the byte-lane decoder.
package ahb_code_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HR_OKAY  = 2'b00,
    HR_ERROR = 2'b01
  } hresp_t;

  typedef enum logic [2:0] {
    HS_BYTE = 3'b000,
    HS_HALF = 3'b001,
    HS_WORD = 3'b010
  } hsize_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RDATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  function automatic logic [3:0] be_decode(
    input logic [2:0] sz,
    input logic [1:0] a
  );
    logic [3:0] be;
    be = 4'b0000;
    unique case (1'b1)
      (sz == HS_BYTE): be = 4'b0001 << a;
      (sz == HS_HALF): be = a[1] ? 4'b1100 : 4'b0011;
      default:         be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_excl_monitor.sv
// Single-entry exclusive monitor: set by exclusive reads,
// consumed by exclusive writes, cleared by plain writes that hit.
module ahb_excl_monitor
  import ahb_code_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_set,
  input  logic          i_chk,
  input  logic          i_wr,
  input  logic [AW-1:0] i_addr,
  output logic          o_pass
);

  logic          r_valid;
  logic [AW-1:0] r_addr;
  logic          w_hit;
  logic          w_clr;

  assign w_hit  = r_valid & (r_addr == i_addr);
  assign w_clr  = i_wr & w_hit;
  assign o_pass = i_chk & w_hit & ~w_clr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else if (w_clr | i_chk) begin
      r_valid <= 1'b0;
    end else if (i_set) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
    end
  end

endmodule

// File: rtl/ahb_code_sram_slave.sv
// AHB-Lite code-bus SRAM responder with wait states, two-cycle
// ERROR and exclusive response; SRAM has one-cycle read latency.
module ahb_code_sram_slave
  import ahb_code_pkg::*;
#(
  parameter  int MEM_BYTES   = 65536,
  parameter  int WAIT_STATES = 0,
  localparam int MEM_AW      = $clog2(MEM_BYTES) - 2
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic [31:0]       HWDATA,
  input  logic              EXREQ,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [31:0]       HRDATA,
  output logic [1:0]        HRESP,
  output logic              EXRESP,
  output logic              MEM_CS,
  output logic              MEM_WE,
  output logic [3:0]        MEM_WBE,
  output logic [MEM_AW-1:0] MEM_ADDR,
  output logic [31:0]       MEM_WDATA,
  input  logic [31:0]       MEM_RDATA
);

  state_t            r_state;
  state_t            w_seq;
  state_t            w_next;
  logic [MEM_AW-1:0] r_addr;
  logic              r_write;
  logic              r_excl;
  logic              r_xpass;
  logic              r_cap;
  logic [3:0]        r_be;
  logic [3:0]        r_cnt;
  logic [31:0]       r_rdata;
  logic [31:0]       w_hold;
  logic              w_accept;
  logic              w_err;
  logic              w_done;
  logic              w_acc;
  logic              w_cs;
  logic              w_pass;
  logic              w_xok;
  logic              w_unused;

  assign w_unused = ^{HBURST, HPROT};

  assign w_accept = HSEL & HREADY &
                    ((HTRANS == HT_NONSEQ) | (HTRANS == HT_SEQ));
  assign w_err    = (HADDR >= 32'(MEM_BYTES)) |
                    (HSIZE > HS_WORD) |
                    ((HSIZE == HS_HALF) & HADDR[0]) |
                    ((HSIZE == HS_WORD) & (|HADDR[1:0]));
  assign w_acc    = (r_state == ST_ACCESS);

  ahb_excl_monitor #(
    .AW(MEM_AW)
  ) u_mon (
    .i_clk (HCLK),
    .i_rst (HRESET),
    .i_set (w_acc & ~r_write & r_excl),
    .i_chk (w_acc & r_write & r_excl),
    .i_wr  (w_acc & r_write & ~r_excl),
    .i_addr(r_addr),
    .o_pass(w_pass)
  );

  always_comb begin
    w_seq   = r_state;
    w_done  = 1'b0;
    w_cs    = 1'b0;
    HRESP   = HR_OKAY;
    MEM_WBE = 4'b0000;
    unique case (r_state)
      ST_IDLE: w_done = 1'b1;
      ST_ACCESS: begin
        // a failed exclusive write never reaches the array
        w_cs = ~(r_write & r_excl & ~w_pass);
        if (r_write & w_cs) MEM_WBE = r_be;
        if (WAIT_STATES != 0) w_seq = ST_WAIT;
        else if (r_write)     w_done = 1'b1;
        else                  w_seq = ST_RDATA;
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          if (r_write) w_done = 1'b1;
          else         w_seq = ST_RDATA;
        end
      end
      ST_RDATA: w_done = 1'b1;
      ST_ERR1: begin
        HRESP = HR_ERROR;
        w_seq = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP  = HR_ERROR;
        w_done = 1'b1;
      end
      default: w_seq = ST_IDLE;
    endcase
  end

  assign w_next = !w_done   ? w_seq :
                  !w_accept ? ST_IDLE :
                  w_err     ? ST_ERR1 : ST_ACCESS;

  assign w_xok = (r_state == ST_RDATA) |
                 (w_acc & w_pass) |
                 ((r_state == ST_WAIT) & r_xpass);

  assign w_hold    = r_cap ? MEM_RDATA : r_rdata;
  assign HRDATA    = (r_state == ST_RDATA) ? w_hold : 32'h0;
  assign HREADYOUT = w_done;
  assign EXRESP    = w_done & r_excl & w_xok;
  assign MEM_CS    = w_cs;
  assign MEM_WE    = w_cs & r_write;
  assign MEM_ADDR  = r_addr;
  assign MEM_WDATA = HWDATA;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_excl  <= 1'b0;
      r_be    <= 4'b0000;
      r_cnt   <= 4'd0;
      r_xpass <= 1'b0;
      r_cap   <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_state <= w_next;
      r_cap   <= w_acc & ~r_write;
      r_rdata <= w_hold;
      if (w_acc) begin
        r_xpass <= w_pass;
        r_cnt   <= 4'(WAIT_STATES - 1);
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_done & w_accept) begin
        r_addr  <= HADDR[MEM_AW+1:2];
        r_write <= HWRITE;
        r_excl  <= EXREQ;
        r_be    <= be_decode(HSIZE, HADDR[1:0]);
      end
    end
  end

endmodule

// File: tb/tb_ahb_code_sram_slave.sv
// Directed bench: zero-wait and three-wait-state instances, each
// backed by a behavioural one-cycle-latency SRAM.
module tb_ahb_code_sram_slave;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        HRESET, sel0, sel3, HWRITE, EXREQ, dsel;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;

  logic        ro0, ro3, ex0, ex3, cs0, cs3, we0, we3;
  logic [31:0] rd0, rd3, wd0, wd3, mr0, mr3;
  logic [1:0]  rsp0, rsp3;
  logic [3:0]  wbe0, wbe3;
  logic [13:0] ad0, ad3;
  logic [31:0] mem0 [16384];
  logic [31:0] mem3 [16384];

  ahb_code_sram_slave #(.MEM_BYTES(65536), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel0), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .EXREQ(EXREQ), .HREADY(ro0),
    .HREADYOUT(ro0), .HRDATA(rd0), .HRESP(rsp0), .EXRESP(ex0),
    .MEM_CS(cs0), .MEM_WE(we0), .MEM_WBE(wbe0), .MEM_ADDR(ad0),
    .MEM_WDATA(wd0), .MEM_RDATA(mr0)
  );

  ahb_code_sram_slave #(.MEM_BYTES(65536), .WAIT_STATES(3)) u_dut3 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel3), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .EXREQ(EXREQ), .HREADY(ro3),
    .HREADYOUT(ro3), .HRDATA(rd3), .HRESP(rsp3), .EXRESP(ex3),
    .MEM_CS(cs3), .MEM_WE(we3), .MEM_WBE(wbe3), .MEM_ADDR(ad3),
    .MEM_WDATA(wd3), .MEM_RDATA(mr3)
  );

  always @(posedge HCLK) begin
    if (cs0 && we0) begin
      for (int b = 0; b < 4; b++)
        if (wbe0[b]) mem0[ad0][8*b +: 8] <= wd0[8*b +: 8];
    end else if (cs0) begin
      mr0 <= mem0[ad0];
    end
  end

  always @(posedge HCLK) begin
    if (cs3 && we3) begin
      for (int b = 0; b < 4; b++)
        if (wbe3[b]) mem3[ad3][8*b +: 8] <= wd3[8*b +: 8];
    end else if (cs3) begin
      mr3 <= mem3[ad3];
    end
  end

  logic        s_ready, s_ex, s_cs, s_we;
  logic [31:0] s_rd, s_wd;
  logic [1:0]  s_rsp;
  logic [3:0]  s_wbe;
  logic [13:0] s_ma;
  assign s_ready = dsel ? ro3  : ro0;
  assign s_ex    = dsel ? ex3  : ex0;
  assign s_cs    = dsel ? cs3  : cs0;
  assign s_we    = dsel ? we3  : we0;
  assign s_rd    = dsel ? rd3  : rd0;
  assign s_wd    = dsel ? wd3  : wd0;
  assign s_rsp   = dsel ? rsp3 : rsp0;
  assign s_wbe   = dsel ? wbe3 : wbe0;
  assign s_ma    = dsel ? ad3  : ad0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic        ex;
    logic [31:0] rd;
    logic [1:0]  rsp;
    logic        exr;
    int          cyc;
    logic        cs;
    logic        we;
    logic [3:0]  wbe;
  } vec_t;

  vec_t v[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] t_rd;
  logic [1:0]  t_rsp, t_rsp1;
  logic        t_exr, t_cs, t_we, t_done, t_exbad;
  logic [3:0]  t_wbe;
  logic [13:0] t_ma;
  int          t_cyc;

  function automatic vec_t mk(
    logic wr, logic [31:0] addr, logic [2:0] sz, logic [31:0] wd,
    logic ex, logic [31:0] rd, logic [1:0] rsp, logic exr, int cyc,
    logic cs, logic we, logic [3:0] wbe);
    vec_t r;
    r.wr = wr; r.addr = addr; r.sz = sz; r.wd = wd; r.ex = ex;
    r.rd = rd; r.rsp = rsp; r.exr = exr; r.cyc = cyc;
    r.cs = cs; r.we = we; r.wbe = wbe;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] a,
                            input logic [2:0] sz, input logic ex);
    sel0 = ~dsel; sel3 = dsel;
    HADDR = a; HTRANS = 2'b10; HWRITE = wr; HSIZE = sz; EXREQ = ex;
  endtask

  task automatic idle_bus();
    sel0 = 1'b0; sel3 = 1'b0;
    HTRANS = 2'b00; HWRITE = 1'b0; EXREQ = 1'b0;
  endtask

  task automatic data_phase(input logic [31:0] wd);
    HWDATA = wd;
    t_cyc = 0; t_cs = 0; t_we = 0; t_wbe = 0; t_ma = 0;
    t_done = 0; t_rsp1 = 0; t_exbad = 0;
    t_rd = 0; t_rsp = 0; t_exr = 0;
    while (!t_done && t_cyc < 40) begin
      @(negedge HCLK);
      t_cyc++;
      if (t_cyc == 1) t_rsp1 = s_rsp;
      if (s_cs) begin
        t_cs = 1; t_ma = s_ma; t_wbe = s_wbe;
        if (s_we) t_we = 1;
      end
      if (s_ready) begin
        t_done = 1; t_rd = s_rd; t_rsp = s_rsp; t_exr = s_ex;
      end else if (s_ex) begin
        t_exbad = 1;
      end
      @(posedge HCLK); #1;
    end
    chk("timeout", {31'b0, t_done}, 32'd1);
  endtask

  task automatic xfer(input vec_t x);
    addr_phase(x.wr, x.addr, x.sz, x.ex);
    @(posedge HCLK); #1;
    idle_bus();
    data_phase(x.wd);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          rcyc, wcyc;
    logic [7:0]  pat;
    string       nm;

    HRESET = 1; dsel = 0; HBURST = 3'b000; HPROT = 4'b0011;
    HWDATA = 0; HADDR = 0; HSIZE = 0;
    idle_bus();
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    for (int d = 0; d < 2; d++) begin
      dsel = d[0];
      #1;
      chk($sformatf("rst%0d.ready", d), {31'b0, s_ready}, 1);
      chk($sformatf("rst%0d.resp", d),  {30'b0, s_rsp}, 0);
      chk($sformatf("rst%0d.exresp", d), {31'b0, s_ex}, 0);
      chk($sformatf("rst%0d.cs", d),    {31'b0, s_cs}, 0);
      chk($sformatf("rst%0d.we", d),    {31'b0, s_we}, 0);
      chk($sformatf("rst%0d.wbe", d),   {28'b0, s_wbe}, 0);
      chk($sformatf("rst%0d.rdata", d), s_rd, 0);
    end
    dsel = 0;
    @(posedge HCLK); #1;
    HRESET = 0;

    v.push_back(mk(1, 32'h100,   2, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1, 1, 4'hF));
    v.push_back(mk(0, 32'h100,   2, 0, 0, 32'hDEADBEEF, 0, 0, 2, 1, 0, 0));
    v.push_back(mk(1, 32'h103,   0, 32'hAA000000, 0, 0, 0, 0, 1, 1, 1, 4'h8));
    v.push_back(mk(0, 32'h100,   2, 0, 0, 32'hAAADBEEF, 0, 0, 2, 1, 0, 0));
    v.push_back(mk(0, 32'h10000, 2, 0, 0, 0, 1, 0, 2, 0, 0, 0));
    v.push_back(mk(1, 32'h300,   2, 32'h0, 0, 0, 0, 0, 1, 1, 1, 4'hF));
    v.push_back(mk(1, 32'h302,   1, 32'hCAFE0000, 0, 0, 0, 0, 1, 1, 1, 4'hC));
    v.push_back(mk(1, 32'h300,   1, 32'h0000BEAD, 0, 0, 0, 0, 1, 1, 1, 4'h3));
    v.push_back(mk(0, 32'h300,   2, 0, 0, 32'hCAFEBEAD, 0, 0, 2, 1, 0, 0));
    v.push_back(mk(0, 32'h301,   1, 0, 0, 0, 1, 0, 2, 0, 0, 0));
    v.push_back(mk(0, 32'h302,   2, 0, 0, 0, 1, 0, 2, 0, 0, 0));
    v.push_back(mk(1, 32'h300,   3, 32'h1, 0, 0, 1, 0, 2, 0, 0, 0));
    v.push_back(mk(0, 32'h301,   0, 0, 0, 32'hCAFEBEAD, 0, 0, 2, 1, 0, 0));
    v.push_back(mk(1, 32'h200,   2, 32'h0, 0, 0, 0, 0, 1, 1, 1, 4'hF));
    v.push_back(mk(0, 32'h200,   2, 0, 1, 0, 0, 1, 2, 1, 0, 0));
    v.push_back(mk(1, 32'h200,   2, 32'h11111111, 1, 0, 0, 1, 1, 1, 1, 4'hF));
    v.push_back(mk(0, 32'h200,   2, 0, 0, 32'h11111111, 0, 0, 2, 1, 0, 0));
    v.push_back(mk(0, 32'h200,   2, 0, 1, 32'h11111111, 0, 1, 2, 1, 0, 0));
    v.push_back(mk(1, 32'h200,   2, 32'h22222222, 0, 0, 0, 0, 1, 1, 1, 4'hF));
    v.push_back(mk(1, 32'h200,   2, 32'h33333333, 1, 0, 0, 0, 1, 0, 0, 0));
    v.push_back(mk(0, 32'h200,   2, 0, 0, 32'h22222222, 0, 0, 2, 1, 0, 0));
    v.push_back(mk(1, 32'h200,   2, 32'h44444444, 1, 0, 0, 0, 1, 0, 0, 0));
    v.push_back(mk(1, 32'h204,   2, 32'h0, 0, 0, 0, 0, 1, 1, 1, 4'hF));
    v.push_back(mk(0, 32'h204,   2, 0, 1, 0, 0, 1, 2, 1, 0, 0));
    v.push_back(mk(1, 32'h200,   2, 32'h55555555, 1, 0, 0, 0, 1, 0, 0, 0));
    v.push_back(mk(1, 32'h204,   2, 32'h66666666, 1, 0, 0, 0, 1, 0, 0, 0));
    v.push_back(mk(0, 32'h204,   2, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    v.push_back(mk(1, 32'hFFFC,  2, 32'h0, 0, 0, 0, 0, 1, 1, 1, 4'hF));
    v.push_back(mk(1, 32'hFFFF,  0, 32'h55000000, 0, 0, 0, 0, 1, 1, 1, 4'h8));
    v.push_back(mk(0, 32'hFFFC,  2, 0, 0, 32'h55000000, 0, 0, 2, 1, 0, 0));
    v.push_back(mk(0, 32'hFFFE,  1, 0, 0, 32'h55000000, 0, 0, 2, 1, 0, 0));
    v.push_back(mk(1, 32'h10000, 0, 32'h77, 0, 0, 1, 0, 2, 0, 0, 0));

    dsel = 0;
    foreach (v[i]) begin
      xfer(v[i]);
      nm = $sformatf("v%0d", i);
      chk({nm, ".cyc"},   t_cyc, v[i].cyc);
      chk({nm, ".resp"},  {30'b0, t_rsp}, {30'b0, v[i].rsp});
      chk({nm, ".resp1"}, {30'b0, t_rsp1}, {30'b0, v[i].rsp});
      chk({nm, ".rdata"}, t_rd, v[i].rd);
      chk({nm, ".exresp"}, {31'b0, t_exr}, {31'b0, v[i].exr});
      chk({nm, ".exearly"}, {31'b0, t_exbad}, 0);
      chk({nm, ".cs"},    {31'b0, t_cs}, {31'b0, v[i].cs});
      chk({nm, ".we"},    {31'b0, t_we}, {31'b0, v[i].we});
      chk({nm, ".wbe"},   {28'b0, t_wbe}, {28'b0, v[i].wbe});
      if (v[i].cs) chk({nm, ".maddr"}, {18'b0, t_ma}, {18'b0, v[i].addr[15:2]});
    end

    // BUSY and unselected NONSEQ are ignored with a zero-wait OKAY
    sel0 = 1; HTRANS = 2'b01; HADDR = 32'h100; HWRITE = 1;
    @(posedge HCLK); #1;
    sel0 = 0; HTRANS = 2'b10;
    @(negedge HCLK);
    chk("busy.ready", {31'b0, s_ready}, 1);
    chk("busy.cs", {31'b0, s_cs}, 0);
    @(posedge HCLK); #1;
    idle_bus();
    @(negedge HCLK);
    chk("nosel.ready", {31'b0, s_ready}, 1);
    chk("nosel.cs", {31'b0, s_cs}, 0);
    @(posedge HCLK); #1;

    dsel = 1;
    xfer(mk(1, 32'h100, 2, 32'h12345678, 0, 0, 0, 0, 4, 1, 1, 4'hF));
    chk("w3.cyc", t_cyc, 4);
    chk("w3.resp", {30'b0, t_rsp}, 0);

    // read with the next write address held through its wait states
    addr_phase(0, 32'h100, 2, 0);
    @(posedge HCLK); #1;
    addr_phase(1, 32'h104, 2, 0);
    HWDATA = 0; rcyc = 0; pat = 0; t_done = 0; t_rd = 0;
    while (!t_done && rcyc < 40) begin
      @(negedge HCLK);
      rcyc++;
      pat = {pat[6:0], s_ready};
      if (s_ready) begin t_done = 1; t_rd = s_rd; end
      @(posedge HCLK); #1;
    end
    idle_bus();
    HWDATA = 32'h9ABCDEF0;
    chk("b2b.rcyc", rcyc, 5);
    chk("b2b.rpat", {27'b0, pat[4:0]}, 32'b00001);
    chk("b2b.rdata", t_rd, 32'h12345678);
    @(negedge HCLK);
    chk("b2b.cs", {31'b0, s_cs}, 1);
    chk("b2b.we", {31'b0, s_we}, 1);
    chk("b2b.maddr", {18'b0, s_ma}, 32'h41);
    chk("b2b.wdata", s_wd, 32'h9ABCDEF0);
    wcyc = 1;
    while (!s_ready && wcyc < 40) begin
      @(posedge HCLK); #1;
      @(negedge HCLK);
      wcyc++;
    end
    chk("b2b.wcyc", wcyc, 4);
    @(posedge HCLK); #1;
    xfer(mk(0, 32'h104, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("r3.cyc", t_cyc, 5);
    chk("r3.rdata", t_rd, 32'h9ABCDEF0);

    // arm the monitor, then reset in the middle of a waited read
    xfer(mk(0, 32'h200, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    chk("x3.exresp", {31'b0, t_exr}, 1);
    addr_phase(0, 32'h100, 2, 0);
    @(posedge HCLK); #1;
    idle_bus();
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("mid.ready", {31'b0, s_ready}, 0);
    HRESET = 1;
    @(posedge HCLK); #1;
    HRESET = 0;
    @(negedge HCLK);
    chk("rstw.ready", {31'b0, s_ready}, 1);
    chk("rstw.cs", {31'b0, s_cs}, 0);
    chk("rstw.rdata", s_rd, 0);
    chk("rstw.resp", {30'b0, s_rsp}, 0);
    @(posedge HCLK); #1;
    xfer(mk(1, 32'h200, 2, 32'hABCDABCD, 1, 0, 0, 0, 0, 0, 0, 0));
    chk("rstx.exresp", {31'b0, t_exr}, 0);
    chk("rstx.cs", {31'b0, t_cs}, 0);
    chk("rstx.we", {31'b0, t_we}, 0);
    chk("rstx.cyc", t_cyc, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
